// File: rtl/ysyx_22040237_lsu_pkg.sv
// ============================================================================
// Module : ysyx_22040237_lsu_pkg
// Brief  : Memory op codes, access-size decode helpers and LSU state encoding
//          shared by the multi-cycle load/store unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ysyx_22040237_lsu_pkg;

    // Memory op codes as driven by EXU; codes 12-15 behave as NONE.
    localparam logic [3:0] MEMOP_NONE = 4'd0;
    localparam logic [3:0] MEMOP_LB   = 4'd1;
    localparam logic [3:0] MEMOP_LH   = 4'd2;
    localparam logic [3:0] MEMOP_LW   = 4'd3;
    localparam logic [3:0] MEMOP_LD   = 4'd4;
    localparam logic [3:0] MEMOP_LBU  = 4'd5;
    localparam logic [3:0] MEMOP_LHU  = 4'd6;
    localparam logic [3:0] MEMOP_LWU  = 4'd7;
    localparam logic [3:0] MEMOP_SB   = 4'd8;
    localparam logic [3:0] MEMOP_SH   = 4'd9;
    localparam logic [3:0] MEMOP_SW   = 4'd10;
    localparam logic [3:0] MEMOP_SD   = 4'd11;

    // log2 of the access size in bytes
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    function automatic logic memop_is_load(input logic [3:0] op);
        return (op >= MEMOP_LB) && (op <= MEMOP_LWU);
    endfunction

    function automatic logic memop_is_store(input logic [3:0] op);
        return (op >= MEMOP_SB) && (op <= MEMOP_SD);
    endfunction

    function automatic logic memop_is_mem(input logic [3:0] op);
        return memop_is_load(op) || memop_is_store(op);
    endfunction

    function automatic logic [1:0] memop_size(input logic [3:0] op);
        logic [1:0] size;
        case (op)
            MEMOP_LB, MEMOP_LBU, MEMOP_SB: size = SIZE_B;
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: size = SIZE_H;
            MEMOP_LW, MEMOP_LWU, MEMOP_SW: size = SIZE_W;
            default:                       size = SIZE_D;
        endcase
        return size;
    endfunction

    // Only the narrow signed loads sign-extend; LD fills all 64 bits anyway.
    function automatic logic memop_is_signed(input logic [3:0] op);
        return (op == MEMOP_LB) || (op == MEMOP_LH) || (op == MEMOP_LW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22040237_lsu_align.sv
// ============================================================================
// Module : ysyx_22040237_lsu_align
// Brief  : Combinational alignment helper: misalign check, store byte mask and
//          lane-shifted store data, load lane extraction with extension.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_22040237_lsu_align
    import ysyx_22040237_lsu_pkg::*;
(
    input  logic [3:0]  mem_op,
    input  logic [2:0]  lane,
    input  logic [63:0] store_data,
    input  logic [63:0] rdata,
    output logic        misalign,
    output logic [7:0]  wmask,
    output logic [63:0] wdata,
    output logic [63:0] load_data
);

    logic [1:0]  size;
    logic [7:0]  base_mask;
    logic [63:0] shifted;
    logic        sext;

    // Natural alignment check; non-memory ops are never misaligned.
    always_comb begin
        size     = memop_size(mem_op);
        misalign = 1'b0;
        if (memop_is_mem(mem_op)) begin
            case (size)
                SIZE_H:  misalign = lane[0];
                SIZE_W:  misalign = |lane[1:0];
                SIZE_D:  misalign = |lane;
                default: misalign = 1'b0;
            endcase
        end
    end

    // Byte mask and store data moved into the addressed lane of the doubleword.
    always_comb begin
        case (size)
            SIZE_B:  base_mask = 8'h01;
            SIZE_H:  base_mask = 8'h03;
            SIZE_W:  base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
        wmask = 8'h00;
        wdata = 64'h0;
        if (memop_is_store(mem_op)) begin
            wmask = base_mask << lane;
            wdata = store_data << {lane, 3'b000};
        end
    end

    // Bring the addressed lane down to bit 0, then sign/zero extend by size.
    always_comb begin
        shifted = rdata >> {lane, 3'b000};
        sext    = memop_is_signed(mem_op);
        case (size)
            SIZE_B:  load_data = {{56{sext & shifted[7]}},  shifted[7:0]};
            SIZE_H:  load_data = {{48{sext & shifted[15]}}, shifted[15:0]};
            SIZE_W:  load_data = {{32{sext & shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_22040237_lsu_mc.sv
// ============================================================================
// Module : ysyx_22040237_lsu_mc
// Brief  : Multi-cycle load/store unit between EXU and WBU. One op at a time,
//          one aligned 64-bit memory transaction per load/store.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_22040237_lsu_mc
    import ysyx_22040237_lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              rd_wr_en_i,
    input  logic [4:0]        rd_idx_i,
    input  logic [ADDR_W-1:0] alu_res_i,
    input  logic [3:0]        mem_op_i,
    input  logic [DATA_W-1:0] store_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              rd_wr_en_o,
    output logic [4:0]        rd_idx_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              misalign_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_req_wen_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [DATA_W-1:0] mem_req_wdata_o,
    output logic [7:0]        mem_req_wmask_o,
    input  logic              mem_resp_valid_i,
    input  logic [DATA_W-1:0] mem_resp_rdata_i
);

    lsu_state_e        state_q, state_d;

    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] sdata_q;
    logic [4:0]        idx_q;
    logic              wen_q;

    logic [DATA_W-1:0] rd_data_q;
    logic              rd_wen_q;
    logic              mis_q;

    logic              is_idle, is_req, is_done;
    logic [3:0]        sel_op;
    logic [2:0]        sel_lane;
    logic              misalign;
    logic [7:0]        wmask;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] load_data;

    assign is_idle = (state_q == LSU_IDLE);
    assign is_req  = (state_q == LSU_REQ);
    assign is_done = (state_q == LSU_DONE);

    // In IDLE the helper looks at the incoming op (misalign decision at accept);
    // afterwards it works on the latched op for the request and the response.
    assign sel_op   = is_idle ? mem_op_i        : op_q;
    assign sel_lane = is_idle ? alu_res_i[2:0]  : addr_q[2:0];

    ysyx_22040237_lsu_align u_align (
        .mem_op     (sel_op),
        .lane       (sel_lane),
        .store_data (sdata_q),
        .rdata      (mem_resp_rdata_i),
        .misalign   (misalign),
        .wmask      (wmask),
        .wdata      (wdata),
        .load_data  (load_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= LSU_IDLE;
        else      state_q <= state_d;
    end

    // Next-state: non-memory and misaligned ops skip straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (in_valid_i) begin
                if (!memop_is_mem(mem_op_i) || misalign) state_d = LSU_DONE;
                else                                     state_d = LSU_REQ;
            end
            LSU_REQ:  if (mem_req_ready_i)  state_d = LSU_WAIT;
            LSU_WAIT: if (mem_resp_valid_i) state_d = LSU_DONE;
            LSU_DONE: if (out_ready_i)      state_d = LSU_IDLE;
            default:                        state_d = LSU_IDLE;
        endcase
    end

    // Op latch at accept and write-back result capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= MEMOP_NONE;
            addr_q    <= '0;
            sdata_q   <= '0;
            idx_q     <= 5'd0;
            wen_q     <= 1'b0;
            rd_data_q <= '0;
            rd_wen_q  <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            case (state_q)
                LSU_IDLE: if (in_valid_i) begin
                    op_q      <= mem_op_i;
                    addr_q    <= alu_res_i;
                    sdata_q   <= store_data_i;
                    idx_q     <= rd_idx_i;
                    wen_q     <= rd_wr_en_i;
                    rd_data_q <= memop_is_mem(mem_op_i) ? '0 : alu_res_i;
                    rd_wen_q  <= !memop_is_mem(mem_op_i) && rd_wr_en_i && (rd_idx_i != 5'd0);
                    mis_q     <= misalign;
                end
                LSU_WAIT: if (mem_resp_valid_i) begin
                    rd_data_q <= memop_is_load(op_q) ? load_data : '0;
                    rd_wen_q  <= memop_is_load(op_q) && wen_q && (idx_q != 5'd0);
                end
                default: ;
            endcase
        end
    end

    assign in_ready_o      = is_idle;
    assign out_valid_o     = is_done;
    assign rd_wr_en_o      = is_done & rd_wen_q;
    assign rd_idx_o        = is_done ? idx_q     : 5'd0;
    assign rd_data_o       = is_done ? rd_data_q : '0;
    assign misalign_o      = is_done & mis_q;

    assign mem_req_valid_o = is_req;
    assign mem_req_wen_o   = is_req & memop_is_store(op_q);
    assign mem_req_addr_o  = is_req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
    assign mem_req_wdata_o = is_req ? wdata : '0;
    assign mem_req_wmask_o = is_req ? wmask : 8'h00;

    // A response with no outstanding request indicates a broken memory model.
    a_resp_only_in_wait: assert property (@(posedge clk) disable iff (!rst)
        !(mem_resp_valid_i && (state_q != LSU_WAIT)));

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040237_lsu_mc.sv
// ============================================================================
// Module : tb_ysyx_22040237_lsu_mc
// Brief  : Directed self-checking bench for the multi-cycle LSU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22040237_lsu_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        rd_wr_en_in = 1'b0;
    logic [4:0]  rd_idx_in = 5'd0;
    logic [63:0] alu_res = 64'h0;
    logic [3:0]  mem_op = 4'd0;
    logic [63:0] store_data = 64'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        rd_wr_en_out;
    logic [4:0]  rd_idx_out;
    logic [63:0] rd_data;
    logic        misalign;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid = 1'b0;
    logic [63:0] resp_rdata = 64'h0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_22040237_lsu_mc #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .rd_wr_en_i       (rd_wr_en_in),
        .rd_idx_i         (rd_idx_in),
        .alu_res_i        (alu_res),
        .mem_op_i         (mem_op),
        .store_data_i     (store_data),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .rd_wr_en_o       (rd_wr_en_out),
        .rd_idx_o         (rd_idx_out),
        .rd_data_o        (rd_data),
        .misalign_o       (misalign),
        .mem_req_valid_o  (req_valid),
        .mem_req_ready_i  (req_ready),
        .mem_req_wen_o    (req_wen),
        .mem_req_addr_o   (req_addr),
        .mem_req_wdata_o  (req_wdata),
        .mem_req_wmask_o  (req_wmask),
        .mem_resp_valid_i (resp_valid),
        .mem_resp_rdata_i (resp_rdata)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single accept edge, then scramble the inputs so
    // that any dependence on unlatched inputs shows up.
    task automatic issue(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] sdata,
                         input logic [4:0] idx, input logic wen);
        mem_op      = op;
        alu_res     = addr;
        store_data  = sdata;
        rd_idx_in   = idx;
        rd_wr_en_in = wen;
        in_valid    = 1'b1;
        tick();
        in_valid    = 1'b0;
        mem_op      = 4'd4;
        alu_res     = ~addr;
        store_data  = ~sdata;
        rd_idx_in   = ~idx;
        rd_wr_en_in = ~wen;
    endtask

    task automatic none_run(input string tag, input logic [3:0] op, input logic [63:0] alu,
                            input logic [4:0] idx, input logic wen, input logic exp_wen);
        check_val({tag, " in_ready"}, {63'd0, in_ready}, 64'd1);
        issue(op, alu, 64'h0, idx, wen);
        check_val({tag, " out_valid N+1"}, {63'd0, out_valid}, 64'd1);
        check_val({tag, " no req"}, {63'd0, req_valid}, 64'd0);
        check_val({tag, " rd_data"}, rd_data, alu);
        check_val({tag, " rd_wr_en"}, {63'd0, rd_wr_en_out}, {63'd0, exp_wen});
        check_val({tag, " rd_idx"}, {59'd0, rd_idx_out}, {59'd0, idx});
        check_val({tag, " misalign"}, {63'd0, misalign}, 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val({tag, " back idle"}, {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    task automatic mis_run(input string tag, input logic [3:0] op, input logic [63:0] addr);
        issue(op, addr, 64'h1234, 5'd7, 1'b1);
        check_val({tag, " no req"}, {63'd0, req_valid}, 64'd0);
        check_val({tag, " out_valid N+1"}, {63'd0, out_valid}, 64'd1);
        check_val({tag, " misalign"}, {63'd0, misalign}, 64'd1);
        check_val({tag, " rd_wr_en"}, {63'd0, rd_wr_en_out}, 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val({tag, " back idle"}, {61'd0, req_valid, out_valid, in_ready}, 64'd1);
    endtask

    task automatic mem_run(input string tag, input logic [3:0] op, input logic [63:0] addr,
                           input logic [63:0] sdata, input logic [4:0] idx, input logic [63:0] rdata,
                           input int req_stall, input int out_stall,
                           input logic [63:0] exp_addr, input logic exp_store,
                           input logic [7:0] exp_wmask, input logic [63:0] exp_wdata,
                           input logic [63:0] exp_data, input logic exp_wen);
        check_val({tag, " in_ready"}, {63'd0, in_ready}, 64'd1);
        issue(op, addr, sdata, idx, 1'b1);
        for (int i = 0; i <= req_stall; i++) begin
            check_val({tag, " req_valid"}, {63'd0, req_valid}, 64'd1);
            check_val({tag, " req_addr"}, req_addr, exp_addr);
            check_val({tag, " req_wen"}, {63'd0, req_wen}, {63'd0, exp_store});
            check_val({tag, " req_wmask"}, {56'd0, req_wmask}, {56'd0, exp_wmask});
            if (exp_store) check_val({tag, " req_wdata"}, req_wdata, exp_wdata);
            check_val({tag, " busy"}, {62'd0, in_ready, out_valid}, 64'd0);
            if (i == req_stall) req_ready = 1'b1;
            tick();
        end
        req_ready = 1'b0;
        check_val({tag, " wait no req"}, {62'd0, req_valid, out_valid}, 64'd0);
        resp_valid = 1'b1;
        resp_rdata = rdata;
        tick();
        resp_valid = 1'b0;
        resp_rdata = 64'h0;
        for (int i = 0; i <= out_stall; i++) begin
            check_val({tag, " out_valid"}, {63'd0, out_valid}, 64'd1);
            if (!exp_store) check_val({tag, " rd_data"}, rd_data, exp_data);
            check_val({tag, " rd_wr_en"}, {63'd0, rd_wr_en_out}, {63'd0, exp_wen});
            check_val({tag, " rd_idx"}, {59'd0, rd_idx_out}, {59'd0, idx});
            check_val({tag, " misalign"}, {63'd0, misalign}, 64'd0);
            check_val({tag, " in_ready"}, {63'd0, in_ready}, 64'd0);
            if (i == out_stall) out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        check_val({tag, " back idle"}, {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check_val("reset in_ready", {63'd0, in_ready}, 64'd1);
        check_val("reset outputs",
                  {58'd0, out_valid, rd_wr_en_out, misalign, req_valid, req_wen, |rd_idx_out}, 64'd0);
        check_val("reset rd_data", rd_data, 64'd0);
        check_val("reset req bus", req_addr | req_wdata | {56'd0, req_wmask}, 64'd0);
        rst = 1'b1;
        tick();

        // Pass-through ops
        none_run("none", 4'd0, 64'hDEAD_BEEF_CAFE_F00D, 5'd3, 1'b1, 1'b1);
        none_run("op13 x0", 4'd13, 64'h0000_0000_0000_0042, 5'd0, 1'b1, 1'b0);
        none_run("none nowen", 4'd15, 64'h8000_0000_0000_0001, 5'd9, 1'b0, 1'b0);

        // Loads
        mem_run("LD", 4'd4, 64'h8000_0008, 64'h0, 5'd10, 64'h1122_3344_5566_7788, 0, 0,
                64'h8000_0008, 1'b0, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 1'b1);
        mem_run("LB", 4'd1, 64'h8000_0003, 64'h0, 5'd11, 64'h0000_0000_8000_0000, 0, 0,
                64'h8000_0000, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b1);
        mem_run("LBU", 4'd5, 64'h8000_0003, 64'h0, 5'd11, 64'h0000_0000_8000_0000, 0, 0,
                64'h8000_0000, 1'b0, 8'h00, 64'h0, 64'h0000_0000_0000_0080, 1'b1);
        mem_run("LH", 4'd2, 64'h8000_0002, 64'h0, 5'd12, 64'h0000_0000_8001_0000, 0, 0,
                64'h8000_0000, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1'b1);
        mem_run("LHU", 4'd6, 64'h8000_0002, 64'h0, 5'd12, 64'h0000_0000_8001_0000, 0, 0,
                64'h8000_0000, 1'b0, 8'h00, 64'h0, 64'h0000_0000_0000_8001, 1'b1);
        mem_run("LW", 4'd3, 64'h8000_0004, 64'h0, 5'd13, 64'h8000_0000_0000_0000, 0, 0,
                64'h8000_0000, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_8000_0000, 1'b1);
        mem_run("LWU", 4'd7, 64'h8000_0004, 64'h0, 5'd13, 64'h8000_0000_0000_0000, 0, 0,
                64'h8000_0000, 1'b0, 8'h00, 64'h0, 64'h0000_0000_8000_0000, 1'b1);
        mem_run("LB x0", 4'd1, 64'h8000_0007, 64'h0, 5'd0, 64'h7F00_0000_0000_0000, 0, 0,
                64'h8000_0000, 1'b0, 8'h00, 64'h0, 64'h0000_0000_0000_007F, 1'b0);

        // Stores
        mem_run("SH", 4'd9, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 5'd5, 64'h5555_5555_5555_5555, 0, 0,
                64'h8000_0000, 1'b1, 8'hC0, 64'hABCD_0000_0000_0000, 64'h0, 1'b0);
        mem_run("SD", 4'd11, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 5'd6, 64'h0, 0, 0,
                64'h8000_0010, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0);
        mem_run("SW", 4'd10, 64'h8000_0004, 64'h0000_0000_1234_5678, 5'd6, 64'h0, 0, 0,
                64'h8000_0000, 1'b1, 8'hF0, 64'h1234_5678_0000_0000, 64'h0, 1'b0);
        // Back-pressure on both sides
        mem_run("SB stall", 4'd8, 64'h8000_0001, 64'h0000_0000_0000_00A5, 5'd8, 64'h0, 3, 2,
                64'h8000_0000, 1'b1, 8'h02, 64'h0000_0000_0000_A500, 64'h0, 1'b0);
        mem_run("LD stall", 4'd4, 64'h8000_0018, 64'h0, 5'd14, 64'hCAFE_0000_1234_5678, 3, 2,
                64'h8000_0018, 1'b0, 8'h00, 64'h0, 64'hCAFE_0000_1234_5678, 1'b1);

        // Misaligned accesses
        mis_run("mis LW", 4'd3, 64'h8000_0002);
        mis_run("mis LH", 4'd2, 64'h8000_0001);
        mis_run("mis LD", 4'd4, 64'h8000_0004);
        mis_run("mis SW", 4'd10, 64'h8000_0006);

        // Reset while waiting for a response
        issue(4'd4, 64'h8000_0020, 64'h0, 5'd4, 1'b1);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check_val("rst-wait in WAIT", {62'd0, req_valid, in_ready}, 64'd0);
        rst = 1'b0;
        #1;
        check_val("rst-wait in_ready", {63'd0, in_ready}, 64'd1);
        check_val("rst-wait outputs", {62'd0, req_valid, out_valid}, 64'd0);
        tick();
        rst = 1'b1;
        tick();
        check_val("rst-wait idle", {62'd0, out_valid, in_ready}, 64'd1);
        none_run("after rst", 4'd0, 64'h0000_0000_0000_5A5A, 5'd2, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
